imem_port_arbiter: RTL and testbench

IMEM_PORT_ARBITER -- requirements
Module: imem_port_arbiter

---
 rtl/imem_port_arbiter.sv | 128 ++++++++++++
 tb/tb_imem_port_arbiter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_port_arbiter.sv
// rtl/imem_port_arbiter.sv - arbitrates a fetch read port and a loader write port onto one instruction memory
// Round-robin between fetch and loader, with range-checked 1-cycle synchronous-read memory access.
module imem_port_arbiter #(
  parameter int          DEPTH    = 28,
  parameter int          IDX_W    = 5,
  parameter logic [31:0] NOP_WORD = 32'h00000013
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              f_req,
  input  logic [31:0]       f_addr,
  output logic              f_ack,
  output logic [31:0]       f_rdata,
  input  logic              l_req,
  input  logic [31:0]       l_addr,
  input  logic [31:0]       l_wdata,
  input  logic              l_lock,
  output logic              l_ack,
  output logic              l_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [IDX_W-1:0]  mem_idx,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, RD, RDW, WR} state_t;

  state_t             state, state_nxt;
  logic               last_l;
  logic [IDX_W-1:0]   idx_q;
  logic [31:0]        wdata_q;
  logic               oor_q;
  logic               f_elig, l_elig;
  logic               grant_f, grant_l;
  logic [IDX_W-1:0]   f_idx, l_idx;
  logic               unused_addr_bits;

  function automatic logic out_of_range(input logic [IDX_W-1:0] idx);
    return 32'(idx) >= $unsigned(DEPTH);
  endfunction

  assign f_idx = f_addr[IDX_W+1:2];
  assign l_idx = l_addr[IDX_W+1:2];
  assign unused_addr_bits = ^{f_addr[31:IDX_W+2], f_addr[1:0], l_addr[31:IDX_W+2], l_addr[1:0]};

  // A requester whose ack is showing this cycle is already served and must not be re-granted.
  assign f_elig = f_req && !f_ack && !l_lock;
  assign l_elig = l_req && !l_ack;

  assign mem_idx   = idx_q;
  assign mem_wdata = wdata_q;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    grant_f   = 1'b0;
    grant_l   = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    case (state)
      IDLE: begin
        if (f_elig && (!l_elig || last_l)) begin
          grant_f   = 1'b1;
          state_nxt = RD;
        end else if (l_elig) begin
          grant_l   = 1'b1;
          state_nxt = WR;
        end
      end
      RD: begin
        mem_en    = !oor_q;
        state_nxt = RDW;
      end
      RDW: state_nxt = IDLE;
      WR: begin
        mem_en    = !oor_q;
        mem_we    = !oor_q;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_l  <= 1'b1;
      idx_q   <= '0;
      wdata_q <= '0;
      oor_q   <= 1'b0;
      f_ack   <= 1'b0;
      f_rdata <= 32'h0;
      l_ack   <= 1'b0;
      l_err   <= 1'b0;
    end else begin
      f_ack <= 1'b0;
      l_ack <= 1'b0;
      l_err <= 1'b0;
      if (grant_f) begin
        idx_q  <= f_idx;
        oor_q  <= out_of_range(f_idx);
        last_l <= 1'b0;
      end
      if (grant_l) begin
        idx_q   <= l_idx;
        wdata_q <= l_wdata;
        oor_q   <= out_of_range(l_idx);
        last_l  <= 1'b1;
      end
      // Read data arrives during RDW; out-of-range fetches never touched memory.
      if (state == RDW) begin
        f_rdata <= oor_q ? NOP_WORD : mem_rdata;
        f_ack   <= 1'b1;
      end
      if (state == WR) begin
        l_ack <= 1'b1;
        l_err <= oor_q;
      end
    end
  end

endmodule

// File: tb/tb_imem_port_arbiter.sv
// tb/tb_imem_port_arbiter.sv - self-checking bench for imem_port_arbiter
// Memory is emulated here; expected words come from a separate reference copy of memory contents.
module tb_imem_port_arbiter;
  localparam int          DEPTH = 28;
  localparam logic [31:0] NOP   = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        f_req = 1'b0, l_req = 1'b0, l_lock = 1'b0;
  logic [31:0] f_addr = '0, l_addr = '0, l_wdata = '0;
  logic        f_ack, l_ack, l_err, mem_en, mem_we, busy;
  logic [31:0] f_rdata, mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic [4:0]  mem_idx;

  logic [31:0] tb_mem  [0:31];
  logic [31:0] ref_mem [0:31];
  int          n_checks = 0;
  int          n_errors = 0;

  imem_port_arbiter dut (
    .clk(clk), .rst(rst),
    .f_req(f_req), .f_addr(f_addr), .f_ack(f_ack), .f_rdata(f_rdata),
    .l_req(l_req), .l_addr(l_addr), .l_wdata(l_wdata), .l_lock(l_lock),
    .l_ack(l_ack), .l_err(l_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_idx(mem_idx),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en && mem_we)  tb_mem[mem_idx] <= mem_wdata;
    if (mem_en && !mem_we) mem_rdata <= tb_mem[mem_idx];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one fetch from an idle arbiter: grant at the first edge, ack visible after the third.
  task automatic do_fetch(input logic [31:0] addr, input bit drop);
    int          cyc, en_cnt;
    bit          got;
    logic [4:0]  idx, en_idx;
    logic [31:0] exp;
    idx = addr[6:2];
    exp = (int'(idx) < DEPTH) ? ref_mem[idx] : NOP;
    f_req = 1'b1; f_addr = addr;
    cyc = 0; en_cnt = 0; got = 1'b0; en_idx = '0;
    while (!got && cyc < 10) begin
      tick();
      cyc++;
      if (drop && cyc == 1) begin f_req = 1'b0; f_addr = 32'hdeadbeef; end
      if (mem_en) begin en_cnt++; en_idx = mem_idx; check("fetch_we", mem_we, 0); end
      if (f_ack) got = 1'b1;
    end
    f_req = 1'b0;
    check("fetch_ack_seen", got, 1);
    check("fetch_latency", cyc, 3);
    check("fetch_rdata", f_rdata, exp);
    check("fetch_mem_en_cycles", en_cnt, (int'(idx) < DEPTH) ? 1 : 0);
    if (int'(idx) < DEPTH) check("fetch_mem_idx", en_idx, idx);
    tick();
    check("fetch_ack_pulse", f_ack, 0);
    check("fetch_rdata_hold", f_rdata, exp);
    check("fetch_busy_after", busy, 0);
  endtask

  task automatic do_load(input logic [31:0] addr, input logic [31:0] data, input bit drop);
    int          cyc, we_cnt;
    bit          got, inr;
    logic [4:0]  idx, we_idx;
    logic [31:0] we_data;
    idx = addr[6:2];
    inr = int'(idx) < DEPTH;
    l_req = 1'b1; l_addr = addr; l_wdata = data;
    cyc = 0; we_cnt = 0; got = 1'b0; we_idx = '0; we_data = '0;
    while (!got && cyc < 10) begin
      tick();
      cyc++;
      if (drop && cyc == 1) begin l_req = 1'b0; l_addr = 32'h0; l_wdata = 32'hffffffff; end
      if (mem_en && mem_we) begin we_cnt++; we_idx = mem_idx; we_data = mem_wdata; end
      if (l_ack) got = 1'b1;
    end
    l_req = 1'b0;
    check("load_ack_seen", got, 1);
    check("load_latency", cyc, 2);
    check("load_err", l_err, !inr);
    check("load_we_cycles", we_cnt, inr ? 1 : 0);
    if (inr) begin
      check("load_mem_idx", we_idx, idx);
      check("load_mem_wdata", we_data, data);
      ref_mem[idx] = data;
    end
    tick();
    check("load_ack_pulse", l_ack, 0);
    check("load_busy_after", busy, 0);
  endtask

  initial begin
    int          busy_cnt, ack_cnt, both_cnt;
    int          ev_kind[$];
    int          ev_t[$];
    logic [31:0] a, d;
    logic [31:0] ldata;

    for (int i = 0; i < 32; i++) begin
      tb_mem[i]  = $urandom;
      ref_mem[i] = tb_mem[i];
    end
    tb_mem[3]  = 32'h00b50633;
    ref_mem[3] = 32'h00b50633;

    #2 rst = 1'b1;
    #1;
    check("rst_f_ack", f_ack, 0);
    check("rst_l_ack", l_ack, 0);
    check("rst_l_err", l_err, 0);
    check("rst_mem_en", mem_en, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_busy", busy, 0);
    check("rst_f_rdata", f_rdata, 32'h0);
    tick(); tick();
    rst = 1'b0;
    tick();

    do_fetch(32'h0000000C, 1'b0);
    do_load(32'h00000014, 32'h00d67733, 1'b0);
    do_fetch(32'h00000014, 1'b0);
    check("load_then_fetch_word", f_rdata, 32'h00d67733);
    do_fetch(32'h00000070, 1'b0);
    do_load(32'h0000007C, 32'h12345678, 1'b0);

    // Both requesters held from reset: expect fetch, loader, fetch, loader ...
    ldata = 32'h00a00093;
    rst = 1'b1;
    f_req = 1'b1; f_addr = 32'h0;
    l_req = 1'b1; l_addr = 32'h40; l_wdata = ldata;
    tick(); tick();
    rst = 1'b0;
    both_cnt = 0;
    for (int t = 1; t <= 40; t++) begin
      tick();
      if (f_ack && l_ack) both_cnt++;
      if (f_ack) begin
        ev_kind.push_back(0); ev_t.push_back(t);
        check("cont_f_rdata", f_rdata, ref_mem[0]);
      end
      if (l_ack) begin
        ev_kind.push_back(1); ev_t.push_back(t);
        check("cont_l_err", l_err, 0);
        ref_mem[16] = ldata;
      end
    end
    f_req = 1'b0; l_req = 1'b0;
    tick(); tick(); tick();
    check("cont_both_ack", both_cnt, 0);
    check("cont_ack_count", ev_kind.size(), 16);
    if (ev_kind.size() >= 8) begin
      for (int i = 0; i < 8; i++) check("cont_order", ev_kind[i], i % 2);
      check("cont_t0", ev_t[0], 3);
      check("cont_t1", ev_t[1], 5);
      check("cont_t2", ev_t[2], 8);
    end
    do_fetch(32'h00000040, 1'b0);

    // Lock blocks fetch grants; release lets the fetch win on the next edge.
    l_lock = 1'b1; f_req = 1'b1; f_addr = 32'h0C;
    busy_cnt = 0; ack_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (busy) busy_cnt++;
      if (f_ack) ack_cnt++;
    end
    check("lock_busy", busy_cnt, 0);
    check("lock_ack", ack_cnt, 0);
    l_lock = 1'b0;
    tick();
    check("unlock_busy", busy, 1);
    check("unlock_mem_en", mem_en, 1);
    check("unlock_mem_idx", mem_idx, 5'd3);
    tick(); tick();
    check("unlock_f_ack", f_ack, 1);
    check("unlock_f_rdata", f_rdata, ref_mem[3]);
    f_req = 1'b0;
    tick();

    // Lock rising mid-fetch must not abort it.
    f_req = 1'b1; f_addr = 32'h14;
    tick();
    l_lock = 1'b1;
    tick(); tick();
    check("lock_mid_f_ack", f_ack, 1);
    check("lock_mid_f_rdata", f_rdata, ref_mem[5]);
    f_req = 1'b0;
    tick();
    l_lock = 1'b0;

    // Reset during RDW discards the fetch.
    f_req = 1'b1; f_addr = 32'h08;
    tick(); tick();
    rst = 1'b1;
    f_req = 1'b0;
    #1;
    check("rst_mid_mem_en", mem_en, 0);
    check("rst_mid_busy", busy, 0);
    tick();
    rst = 1'b0;
    ack_cnt = 0; busy_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (f_ack) ack_cnt++;
      if (busy) busy_cnt++;
    end
    check("rst_mid_no_ack", ack_cnt, 0);
    check("rst_mid_idle", busy_cnt, 0);

    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      a[6:2] = 5'($urandom_range(0, 31));
      d = $urandom;
      if ($urandom_range(0, 1) == 1) do_load(a, d, 1'($urandom_range(0, 1)));
      else                           do_fetch(a, 1'($urandom_range(0, 1)));
    end

    for (int i = 0; i < DEPTH; i++) check("final_mem", tb_mem[i], ref_mem[i]);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: bench did not finish, checks %0d", n_checks);
    $fatal(1);
  end

endmodule
